// File: rtl/counter_pkg.sv
// Shared constants and types for the parametrised up/down counter.
package counter_pkg;

   // Direction encoding on up_dn.
   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   // Limit behaviour selected by the SATURATE parameter.
   localparam int unsigned MODE_WRAP = 0;
   localparam int unsigned MODE_SAT  = 1;

   // Operation selected on an edge, after priority resolution.
   typedef enum logic [1:0] {
      OpHold,
      OpClear,
      OpLoad,
      OpStep
   } cnt_op_e;

endpackage

// File: rtl/clk_en_prescaler.sv
// Divides an enable stream: tick goes high on every PRESCALE-th enabled cycle.
module clk_en_prescaler #(
   parameter int unsigned PRESCALE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic restart,
   output logic tick
);

   if (PRESCALE <= 1) begin : g_bypass
      // No division needed: every enabled cycle is a tick.
      logic unused_ok;
      assign unused_ok = ^{clk, reset, restart};
      assign tick      = en;
   end else begin : g_div
      localparam int unsigned CntW = $clog2(PRESCALE);
      localparam logic [CntW-1:0] LastVal = CntW'(PRESCALE - 1);

      logic [CntW-1:0] cnt_q, cnt_d;

      // Next phase: restart wins, otherwise advance modulo PRESCALE while enabled.
      always_comb begin
         cnt_d = cnt_q;
         if (restart) begin
            cnt_d = '0;
         end else if (en) begin
            cnt_d = (cnt_q == LastVal) ? '0 : cnt_q + CntW'(1);
         end
      end

      // Phase register.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign tick = en & (cnt_q == LastVal);
   end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with load, clear, wrap/saturate and event flags.
module updown_counter_param
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned MAX_COUNT = (1 << WIDTH) - 1,
   parameter int unsigned SATURATE  = 0,
   parameter int unsigned PRESCALE  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] counter,
   output logic             wrap,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_COUNT);
   localparam bit               SatMode = (SATURATE == MODE_SAT);

   logic [WIDTH-1:0] counter_q, counter_d;
   logic             wrap_q, wrap_d;
   logic             ovf_q, ovf_d;
   logic             tick;
   logic             restart;
   cnt_op_e          op;

   logic [WIDTH-1:0] eff_cnt;
   logic             at_top;
   logic             at_bot;
   logic             boundary;
   logic [WIDTH-1:0] step_val;

   assign restart = clear | load;

   clk_en_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .restart (restart),
      .tick    (tick)
   );

   // Priority: clear over load over step; en only gates stepping.
   always_comb begin
      op = OpHold;
      if (clear) begin
         op = OpClear;
      end else if (load) begin
         op = OpLoad;
      end else if (tick) begin
         op = OpStep;
      end
   end

   // Boundary compare on the clamped count; out-of-range values act as MAX_COUNT.
   always_comb begin
      at_top   = (counter_q >= MaxVal);
      eff_cnt  = at_top ? MaxVal : counter_q;
      at_bot   = (eff_cnt == '0);
      boundary = 1'b0;
      step_val = eff_cnt;
      if (up_dn == DIR_UP) begin
         if (at_top) begin
            boundary = 1'b1;
            step_val = SatMode ? MaxVal : '0;
         end else begin
            step_val = eff_cnt + WIDTH'(1);
         end
      end else begin
         if (at_bot) begin
            boundary = 1'b1;
            step_val = SatMode ? '0 : MaxVal;
         end else begin
            step_val = eff_cnt - WIDTH'(1);
         end
      end
   end

   // Next-state for count and flags.
   always_comb begin
      counter_d = counter_q;
      wrap_d    = 1'b0;
      ovf_d     = ovf_q;
      unique case (op)
         OpClear: begin
            counter_d = '0;
            ovf_d     = 1'b0;
         end
         OpLoad: begin
            counter_d = (load_val > MaxVal) ? MaxVal : load_val;
         end
         OpStep: begin
            counter_d = step_val;
            wrap_d    = boundary;
            if (boundary) begin
               ovf_d = 1'b1;
            end
         end
         default: begin
            counter_d = counter_q;
         end
      endcase
   end

   // State registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         counter_q <= '0;
         wrap_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         counter_q <= counter_d;
         wrap_q    <= wrap_d;
         ovf_q     <= ovf_d;
      end
   end

   assign counter = counter_q;
   assign wrap    = wrap_q;
   assign ovf     = ovf_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: four configurations share one stimulus stream.
module tb_updown_counter_param;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b0;
   logic       up_dn = 1'b1;
   logic       clear = 1'b0;
   logic       load = 1'b0;
   logic [3:0] load_val = 4'd0;

   logic [3:0] cnt0, cnt1, cnt2;
   logic [2:0] cnt3;
   logic       wrap0, wrap1, wrap2, wrap3;
   logic       ovf0, ovf1, ovf2, ovf3;

   int checks = 0;
   int failures = 0;

   // Per-instance configuration and reference state.
   int mx  [N] = '{15, 10, 15, 5};
   int sat [N] = '{0, 1, 0, 0};
   int pre [N] = '{1, 1, 3, 2};
   int wd  [N] = '{4, 4, 4, 3};
   int m_cnt [N];
   int m_psc [N];
   int m_wrap[N];
   int m_ovf [N];

   always #5 clk = ~clk;

   updown_counter_param u0 (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
      .load_val(load_val), .counter(cnt0), .wrap(wrap0), .ovf(ovf0)
   );

   updown_counter_param #(
      .WIDTH(4), .MAX_COUNT(10), .SATURATE(1), .PRESCALE(1)
   ) u1 (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
      .load_val(load_val), .counter(cnt1), .wrap(wrap1), .ovf(ovf1)
   );

   updown_counter_param #(
      .WIDTH(4), .MAX_COUNT(15), .SATURATE(0), .PRESCALE(3)
   ) u2 (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
      .load_val(load_val), .counter(cnt2), .wrap(wrap2), .ovf(ovf2)
   );

   updown_counter_param #(
      .WIDTH(3), .MAX_COUNT(5), .SATURATE(0), .PRESCALE(2)
   ) u3 (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
      .load_val(load_val[2:0]), .counter(cnt3), .wrap(wrap3), .ovf(ovf3)
   );

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_cnt[i]  = 0;
         m_psc[i]  = 0;
         m_wrap[i] = 0;
         m_ovf[i]  = 0;
      end
   endtask

   // One clock edge of the reference: counts as integers in 0..max.
   task automatic model_edge();
      int  lv;
      bit  tk;
      for (int i = 0; i < N; i++) begin
         tk = en && (m_psc[i] == pre[i] - 1);
         m_wrap[i] = 0;
         if (clear) begin
            m_cnt[i] = 0;
            m_psc[i] = 0;
            m_ovf[i] = 0;
         end else if (load) begin
            lv = int'(load_val) % (1 << wd[i]);
            m_cnt[i] = (lv > mx[i]) ? mx[i] : lv;
            m_psc[i] = 0;
         end else begin
            if (en) m_psc[i] = (m_psc[i] + 1) % pre[i];
            if (tk) begin
               if (up_dn) begin
                  if (m_cnt[i] == mx[i]) begin
                     m_wrap[i] = 1;
                     m_cnt[i]  = sat[i] ? mx[i] : 0;
                  end else begin
                     m_cnt[i] = m_cnt[i] + 1;
                  end
               end else begin
                  if (m_cnt[i] == 0) begin
                     m_wrap[i] = 1;
                     m_cnt[i]  = sat[i] ? 0 : mx[i];
                  end else begin
                     m_cnt[i] = m_cnt[i] - 1;
                  end
               end
               if (m_wrap[i] != 0) m_ovf[i] = 1;
            end
         end
      end
   endtask

   task automatic chk(input string tag, input int inst, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, inst, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("counter", 0, int'(cnt0), m_cnt[0]);
      chk("wrap",    0, int'(wrap0), m_wrap[0]);
      chk("ovf",     0, int'(ovf0), m_ovf[0]);
      chk("counter", 1, int'(cnt1), m_cnt[1]);
      chk("wrap",    1, int'(wrap1), m_wrap[1]);
      chk("ovf",     1, int'(ovf1), m_ovf[1]);
      chk("counter", 2, int'(cnt2), m_cnt[2]);
      chk("wrap",    2, int'(wrap2), m_wrap[2]);
      chk("ovf",     2, int'(ovf2), m_ovf[2]);
      chk("counter", 3, int'(cnt3), m_cnt[3]);
      chk("wrap",    3, int'(wrap3), m_wrap[3]);
      chk("ovf",     3, int'(ovf3), m_ovf[3]);
   endtask

   // Advance one edge, update the model, then sample 1 ns later.
   task automatic cycle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         if (reset) model_reset();
         else model_edge();
         #1;
         check_all();
      end
   endtask

   task automatic set_in(input bit e, input bit u, input bit c, input bit l, input int v);
      en       = e;
      up_dn    = u;
      clear    = c;
      load     = l;
      load_val = 4'(v);
   endtask

   initial begin
      model_reset();
      cycle(2);
      #2 reset = 1'b0;

      // Count up a few, then async reset mid-count for 20 ns.
      set_in(1, 1, 0, 0, 0);
      cycle(5);
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_all();
      cycle(2);
      #2 reset = 1'b0;
      cycle(3);
      chk("post_reset_cnt", 0, int'(cnt0), 3);

      // Full up sweep from 0 on the default instance.
      set_in(0, 1, 1, 0, 0);
      cycle(1);
      set_in(1, 1, 0, 0, 0);
      cycle(15);
      chk("top_cnt", 0, int'(cnt0), 15);
      cycle(1);
      chk("wrap_cnt",   0, int'(cnt0), 0);
      chk("wrap_pulse", 0, int'(wrap0), 1);
      chk("wrap_ovf",   0, int'(ovf0), 1);
      cycle(1);
      chk("wrap_gone",  0, int'(wrap0), 0);

      // Down from 2 through 0 to the top, then clear.
      set_in(1, 0, 0, 1, 2);
      cycle(1);
      set_in(1, 0, 0, 0, 0);
      cycle(3);
      chk("dn_wrap_cnt", 0, int'(cnt0), 15);
      chk("dn_wrap",     0, int'(wrap0), 1);
      set_in(1, 0, 1, 0, 0);
      cycle(1);
      chk("clr_ovf", 0, int'(ovf0), 0);

      // Load with enable, then load and clear together.
      set_in(1, 1, 0, 1, 9);
      cycle(1);
      chk("load_cnt", 0, int'(cnt0), 9);
      set_in(1, 1, 1, 1, 9);
      cycle(1);
      chk("load_clr_cnt", 0, int'(cnt0), 0);

      // Saturation on instance 1: up from 8, then down from 0.
      set_in(1, 1, 0, 1, 8);
      cycle(1);
      set_in(1, 1, 0, 0, 0);
      cycle(4);
      chk("sat_hold",  1, int'(cnt1), 10);
      chk("sat_pulse", 1, int'(wrap1), 1);
      set_in(1, 0, 0, 1, 0);
      cycle(1);
      set_in(1, 0, 0, 0, 0);
      cycle(3);
      chk("sat_zero", 1, int'(cnt1), 0);

      // Load clamp above MAX_COUNT.
      set_in(0, 1, 0, 1, 13);
      cycle(1);
      chk("clamp", 1, int'(cnt1), 10);

      // Prescaled instance: every third enabled edge, stretched by en low.
      set_in(1, 1, 1, 0, 0);
      cycle(1);
      set_in(1, 1, 0, 0, 0);
      cycle(3);
      chk("psc_first", 2, int'(cnt2), 1);
      set_in(0, 1, 0, 0, 0);
      cycle(2);
      set_in(1, 1, 0, 0, 0);
      cycle(2);
      chk("psc_stretch_hold", 2, int'(cnt2), 1);
      cycle(1);
      chk("psc_stretch_step", 2, int'(cnt2), 2);

      // Randomized traffic, with occasional async reset pulses.
      for (int r = 0; r < 600; r++) begin
         set_in(($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1,
                ($urandom_range(0, 39) == 0), ($urandom_range(0, 11) == 0),
                int'($urandom_range(0, 15)));
         if ($urandom_range(0, 99) == 0) begin
            #2 reset = 1'b1;
            #1;
            model_reset();
            check_all();
            #2 reset = 1'b0;
         end
         cycle(1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
